// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte engine and its RX FIFO.
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int RX_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO buffering received SPI words (valid/ready on both sides).
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int DEPTH      = RX_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           count;
  logic                  push;
  logic                  pop;

  // "Full" means every slot is occupied; a same-cycle pop does not make room.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 peripheral byte engine with TX/RX handshakes and overrun detection.
// Define SPI_BYTE_ENGINE_RX_FIFO_EN to buffer received words in a 4-entry FIFO.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int                    MSB_FIRST  = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_FILL  = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck_in,
  input  logic                  sdi_in,
  input  logic                  cs_in,
  output logic                  sdo,
  output logic                  sdo_oe,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  spi_state_e            state;
  logic                  sck_q;
  logic                  cs_q;
  logic                  sck_rise;
  logic                  sck_fall;
  logic                  cs_fall;
  logic                  cs_rise;
  logic                  deselect;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] tx_adv;
  logic                  word_done;
  logic                  store_full;

  // cs_q resets low so a reset released with cs already low produces no cs_fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      sck_q <= sck_in;
      cs_q  <= cs_in;
    end
  end

  assign sck_rise = sck_in && !sck_q;
  assign sck_fall = !sck_in && sck_q;
  assign cs_fall  = !cs_in && cs_q;
  assign cs_rise  = cs_in && !cs_q;
  assign deselect = cs_in || cs_rise;

  assign tx_word   = tx_valid ? tx_data : IDLE_FILL;
  assign tx_adv    = (MSB_FIRST != 0) ? (tx_shift << 1) : (tx_shift >> 1);
  assign rx_next   = (MSB_FIRST != 0) ? {rx_shift[DATA_WIDTH-2:0], sdi_in}
                                      : {sdi_in, rx_shift[DATA_WIDTH-1:1]};
  assign word_done = (state == ST_SHIFT) && !deselect && sck_rise && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      sdo      <= 1'b1;
      sdo_oe   <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (deselect) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        rx_shift <= '0;
        sdo      <= 1'b1;
        sdo_oe   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state  <= ST_LOAD;
              sdo_oe <= 1'b1;
            end
          end
          ST_LOAD: begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            tx_shift <= tx_word;
            tx_ready <= tx_valid;
            sdo      <= (MSB_FIRST != 0) ? tx_word[DATA_WIDTH-1] : tx_word[0];
          end
          ST_SHIFT: begin
            if (sck_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            // A falling edge with the counter at zero sits on a word boundary.
            if (sck_fall) begin
              if (bit_cnt == '0) begin
                tx_shift <= tx_word;
                tx_ready <= tx_valid;
                sdo      <= (MSB_FIRST != 0) ? tx_word[DATA_WIDTH-1] : tx_word[0];
              end else begin
                tx_shift <= tx_adv;
                sdo      <= (MSB_FIRST != 0) ? tx_adv[DATA_WIDTH-1] : tx_adv[0];
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef SPI_BYTE_ENGINE_RX_FIFO_EN
  logic fifo_in_ready;

  spi_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (rx_next),
    .in_valid  (word_done),
    .in_ready  (fifo_in_ready),
    .out_data  (rx_data),
    .out_valid (rx_valid),
    .out_ready (rx_ready)
  );

  assign store_full = !fifo_in_ready;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (word_done && !rx_valid) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end
    end
  end

  assign store_full = rx_valid;
`endif

  // A new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        overrun <= 1'b0;
    else if (word_done && store_full)  overrun <= 1'b1;
    else if (overrun_clr)              overrun <= 1'b0;
  end

endmodule

// File: doc/spi_byte_engine.md
SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per SPI word.
REQ-002 Parameter MSB_FIRST, default 1; 1 shifts MSB first, 0 shifts LSB first.
REQ-003 Parameter IDLE_FILL, default all-ones of DATA_WIDTH, word transmitted when no TX word is offered.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 sck_in  input  1  SPI clock, already synchronized to clk upstream.
REQ-007 sdi_in  input  1  SPI data from controller, already synchronized.
REQ-008 cs_in  input  1  SPI chip select, active-low, already synchronized.
REQ-009 sdo  output  1  SPI data to controller.
REQ-010 sdo_oe  output  1  high while selected; drives the external tristate.
REQ-011 rx_data  output  DATA_WIDTH  received word.
REQ-012 rx_valid / rx_ready  output / input  1 / 1  RX handshake; transfer when both high on a clk edge.
REQ-013 tx_data / tx_valid / tx_ready  input / input / output  DATA_WIDTH / 1 / 1  TX handshake; tx_ready is a one-clk pulse when tx_data is consumed.
REQ-014 overrun  output  1  sticky flag: received word dropped.
REQ-015 overrun_clr  input  1  clears overrun.

Function
REQ-016 Engine SHALL register sck_in and cs_in once and derive sck_rise, sck_fall, cs_fall, cs_rise as single-clk pulses (SPI mode 0).
REQ-017 FSM states: IDLE (cs_in high), LOAD (one clk after cs_fall), SHIFT (selected); IDLE->LOAD on cs_fall, LOAD->SHIFT unconditionally, any state->IDLE when cs_in high.
REQ-018 In LOAD: TX shift register SHALL take tx_data with a tx_ready pulse if tx_valid, else IDLE_FILL; sdo SHALL present the first bit.
REQ-019 In SHIFT, on sck_rise: sample sdi_in into RX shift register, increment bit counter (width clog2(DATA_WIDTH)), wrapping to 0 after DATA_WIDTH-1.
REQ-020 On the sck_rise completing the word, rx_data SHALL update and rx_valid SHALL assert on the following clk (latency 1 clk from the detected edge).
REQ-021 On sck_fall with bit counter 0 (word boundary): reload TX shift register per REQ-018 rules; otherwise advance one bit; sdo updates the same clk.
REQ-022 rx_valid SHALL hold, with rx_data stable, until accepted.
REQ-023 Word completing while RX storage full SHALL be dropped and overrun set; stored data unchanged.
REQ-024 overrun_clr and a simultaneous new overrun: set wins.
REQ-025 cs_rise mid-word SHALL discard the partial word, zero the bit counter, produce no rx_valid; pending RX data retained.
REQ-026 cs_rise coincident with sck_rise: deselect wins, edge ignored.
REQ-027 In IDLE, sdo SHALL be 1 and sdo_oe 0; sck edges ignored.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counter 0, shift registers 0, sdo 1, sdo_oe 0, rx_data 0, rx_valid 0, tx_ready 0, overrun 0, RX storage empty.
REQ-029 rst_n deassertion while cs_in low SHALL stay in IDLE until the next cs_fall.

Configuration
REQ-030 Macro SPI_BYTE_ENGINE_RX_FIFO_EN defined: RX storage is a 4-entry FIFO; "full" = 4 words held; rx_data/rx_valid show the head.
REQ-031 Macro undefined: RX storage is a single holding register; "full" = rx_valid high.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state enum, DATA_WIDTH default, and FIFO depth constant (4).
REQ-033 FIFO SHALL be sub-module spi_rx_fifo (valid/ready both sides, synchronous, same clk/rst_n), instantiated only under the macro.

Verification
REQ-034 cs low, 8 rising edges carrying 0xA5 MSB-first -> rx_data=0xA5, rx_valid high 1 clk after 8th detected rise.
REQ-035 tx_data=0x3C, tx_valid=1 at cs_fall -> one tx_ready pulse in LOAD; sdo at successive rises 0,0,1,1,1,1,0,0.
REQ-036 tx_valid=0 throughout two words -> sdo sends 0xFF, 0xFF; no tx_ready.
REQ-037 cs raised after 5 bits, then new word 0x81 -> no rx_valid for partial; rx_data=0x81 afterwards.
REQ-038 rx_ready=0, words 0x11,0x22 (macro off) -> rx_data=0x11, overrun=1; macro on, 5 words -> first 4 retained in order, overrun on 5th; overrun_clr clears it.
REQ-039 rst_n low mid-word with rx_valid high -> all outputs at REQ-028 values within the same clk, before any edge.
